// File: rtl/target_capture_ctrl.sv
// Capture sequencer: loads the target, follows its busy handshake, returns the result and frames a scope trigger.
// Optional build macro CAPTURE_CTRL_CHAIN_EN feeds each captured result back as the next iteration's data.
module target_capture_ctrl #(
  parameter int DATA_W  = 128,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] pt_i,
  input  logic [DATA_W-1:0] key_i,
  input  logic [CNT_W-1:0]  iter_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] ct_o,
  output logic              trig_o,
  output logic              tgt_load_o,
  output logic [DATA_W-1:0] tgt_data_o,
  output logic [DATA_W-1:0] tgt_key_o,
  input  logic [DATA_W-1:0] tgt_data_i,
  input  logic              tgt_busy_i
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_err;
  logic [DATA_W-1:0] r_ct;
  logic              r_load;
  logic [DATA_W-1:0] r_tdata;
  logic [DATA_W-1:0] r_tkey;

  logic              w_accept;
  logic              w_capture;
  logic              w_timeout;
  logic              w_tmo_hit;
  logic              w_in_wait;
  logic [CNT_W-1:0]  w_iter;

  assign w_tmo_hit = (r_tmo == TMO_LAST);
  assign w_in_wait = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);
  assign w_iter    = (iter_i == '0) ? CNT_W'(1) : iter_i;

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_accept = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_LOAD: w_next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (tgt_busy_i) begin
          w_next = S_WAIT_LO;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_WAIT_LO: begin
        if (!tgt_busy_i) begin
          w_capture = 1'b1;
          w_next    = (r_cnt == CNT_W'(1)) ? S_DONE : S_LOAD;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
      r_ct    <= '0;
      r_load  <= 1'b0;
      r_tdata <= '0;
      r_tkey  <= '0;
    end else begin
      r_state <= w_next;
      r_load  <= (w_next == S_LOAD);
      // Timeout counter restarts on every state change and only runs while waiting
      if ((w_next != r_state) || !w_in_wait) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_accept) begin
        r_cnt   <= w_iter;
        r_err   <= 1'b0;
        r_tdata <= pt_i;
        r_tkey  <= key_i;
      end
      if (w_capture) begin
        r_ct  <= tgt_data_i;
        r_cnt <= r_cnt - 1'b1;
      end
`ifdef CAPTURE_CTRL_CHAIN_EN
      if (w_capture && (w_next == S_LOAD)) begin
        r_tdata <= tgt_data_i;
      end
`endif
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ready_o    = (r_state == S_IDLE);
  assign done_o     = (r_state == S_DONE);
  assign trig_o     = (r_state == S_LOAD) || w_in_wait;
  assign err_o      = r_err;
  assign ct_o       = r_ct;
  assign tgt_load_o = r_load;
  assign tgt_data_o = r_tdata;
  assign tgt_key_o  = r_tkey;

endmodule

// File: tb/tb_target_capture_ctrl.sv
// Directed bench for target_capture_ctrl with a behavioural busy/result target model.
module tb_target_capture_ctrl;
  localparam int DATA_W  = 128;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 64;

  localparam logic [DATA_W-1:0] P1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [DATA_W-1:0] P2 = 128'hFEDCBA98765432100123456789ABCDEF;
  localparam logic [DATA_W-1:0] P3 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [DATA_W-1:0] P4 = 128'h13579BDF2468ACE013579BDF2468ACE0;
  localparam logic [DATA_W-1:0] P5 = 128'hCAFEF00DDEADBEEF0123456789ABCDEF;
  localparam logic [DATA_W-1:0] KA = {16{8'hA5}};
  localparam logic [DATA_W-1:0] K2 = 128'h000102030405060708090A0B0C0D0E0F;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [DATA_W-1:0] pt_i;
  logic [DATA_W-1:0] key_i;
  logic [CNT_W-1:0]  iter_i;
  logic              ready_o;
  logic              done_o;
  logic              err_o;
  logic [DATA_W-1:0] ct_o;
  logic              trig_o;
  logic              tgt_load_o;
  logic [DATA_W-1:0] tgt_data_o;
  logic [DATA_W-1:0] tgt_key_o;
  logic [DATA_W-1:0] tgt_data_i = '0;
  logic              tgt_busy_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Target model: busy for busy_len cycles after a load, result = loaded data ^ xor_mask
  int                busy_len = 1;
  logic [DATA_W-1:0] xor_mask = '0;
  int                r_bcnt   = 0;

  always @(posedge clk) begin
    if (tgt_load_o) begin
      r_bcnt     <= busy_len;
      tgt_data_i <= tgt_data_o ^ xor_mask;
    end else if (r_bcnt > 0) begin
      r_bcnt <= r_bcnt - 1;
    end
  end
  assign tgt_busy_i = (r_bcnt != 0);

  target_capture_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pt_i(pt_i), .key_i(key_i), .iter_i(iter_i),
    .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .ct_o(ct_o), .trig_o(trig_o),
    .tgt_load_o(tgt_load_o), .tgt_data_o(tgt_data_o), .tgt_key_o(tgt_key_o),
    .tgt_data_i(tgt_data_i), .tgt_busy_i(tgt_busy_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observations gathered by issue()
  int                loads;
  int                trigs;
  int                dones;
  int                done_at;
  logic              err_c1;
  logic [DATA_W-1:0] ld_data [4];
  logic [DATA_W-1:0] ld_key;

  // Entered at a negedge while idle; start is sampled at the end of that cycle (S), then limit cycles are observed.
  task automatic issue(input logic [DATA_W-1:0] pt, input logic [DATA_W-1:0] key,
                       input logic [CNT_W-1:0] it, input int limit);
    loads = 0; trigs = 0; dones = 0; done_at = -1; err_c1 = 1'bx; ld_key = '0;
    for (int i = 0; i < 4; i++) ld_data[i] = '0;
    start_i = 1'b1; pt_i = pt; key_i = key; iter_i = it;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_i = 1'b0;
        err_c1  = err_o;
      end
      if (tgt_load_o) begin
        if (loads < 4) ld_data[loads] = tgt_data_o;
        ld_key = tgt_key_o;
        loads++;
      end
      if (trig_o) trigs++;
      if (done_o) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; pt_i = '0; key_i = '0; iter_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", ready_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err_o); end
    n_cmp++; if (trig_o !== 1'b0) begin n_bad++; $display("FAIL rst_trig got %b want 0", trig_o); end
    n_cmp++; if (tgt_load_o !== 1'b0) begin n_bad++; $display("FAIL rst_load got %b want 0", tgt_load_o); end
    n_cmp++; if (ct_o !== '0) begin n_bad++; $display("FAIL rst_ct got %h want 0", ct_o); end
    n_cmp++; if (tgt_data_o !== '0) begin n_bad++; $display("FAIL rst_tdata got %h want 0", tgt_data_o); end
    n_cmp++; if (tgt_key_o !== '0) begin n_bad++; $display("FAIL rst_tkey got %h want 0", tgt_key_o); end
  endtask

  task automatic test_single();
    busy_len = 1; xor_mask = '0;
    issue(P1, KA, 8'd1, 6);
    n_cmp++; if (loads !== 1) begin n_bad++; $display("FAIL single_loads got %0d want 1", loads); end
    n_cmp++; if (trigs !== 3) begin n_bad++; $display("FAIL single_trig_cycles got %0d want 3", trigs); end
    n_cmp++; if (done_at !== 4) begin n_bad++; $display("FAIL single_done_at got %0d want 4", done_at); end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL single_done_pulses got %0d want 1", dones); end
    n_cmp++; if (ld_data[0] !== P1) begin n_bad++; $display("FAIL single_tdata got %h want %h", ld_data[0], P1); end
    n_cmp++; if (ld_key !== KA) begin n_bad++; $display("FAIL single_tkey got %h want %h", ld_key, KA); end
    n_cmp++; if (ct_o !== P1) begin n_bad++; $display("FAIL single_ct got %h want %h", ct_o, P1); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL single_err got %b want 0", err_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL single_ready got %b want 1", ready_o); end
  endtask

  task automatic test_iter_zero();
    busy_len = 1; xor_mask = '0;
    issue(P2, K2, 8'd0, 6);
    n_cmp++; if (loads !== 1) begin n_bad++; $display("FAIL iter0_loads got %0d want 1", loads); end
    n_cmp++; if (done_at !== 4) begin n_bad++; $display("FAIL iter0_done_at got %0d want 4", done_at); end
    n_cmp++; if (ct_o !== P2) begin n_bad++; $display("FAIL iter0_ct got %h want %h", ct_o, P2); end
    n_cmp++; if (ld_key !== K2) begin n_bad++; $display("FAIL iter0_tkey got %h want %h", ld_key, K2); end
  endtask

  task automatic test_multi_iter();
    logic [DATA_W-1:0] exp_d1;
    busy_len = 1; xor_mask = 128'h1;
`ifdef CAPTURE_CTRL_CHAIN_EN
    exp_d1 = P3 ^ 128'h1;
`else
    exp_d1 = P3;
`endif
    issue(P3, KA, 8'd3, 12);
    n_cmp++; if (loads !== 3) begin n_bad++; $display("FAIL multi_loads got %0d want 3", loads); end
    n_cmp++; if (trigs !== 9) begin n_bad++; $display("FAIL multi_trig_cycles got %0d want 9", trigs); end
    n_cmp++; if (done_at !== 10) begin n_bad++; $display("FAIL multi_done_at got %0d want 10", done_at); end
    n_cmp++; if (ld_data[1] !== exp_d1) begin n_bad++; $display("FAIL multi_tdata2 got %h want %h", ld_data[1], exp_d1); end
    n_cmp++; if (ct_o !== (P3 ^ 128'h1)) begin n_bad++; $display("FAIL multi_ct got %h want %h", ct_o, P3 ^ 128'h1); end
  endtask

  task automatic test_timeout();
    busy_len = 0; xor_mask = '0;
    issue(P4, KA, 8'd1, 68);
    n_cmp++; if (done_at !== 2 + TIMEOUT) begin n_bad++; $display("FAIL tmo_done_at got %0d want %0d", done_at, 2 + TIMEOUT); end
    n_cmp++; if (trigs !== 1 + TIMEOUT) begin n_bad++; $display("FAIL tmo_trig_cycles got %0d want %0d", trigs, 1 + TIMEOUT); end
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL tmo_err got %b want 1", err_o); end
    n_cmp++; if (ct_o !== (P3 ^ 128'h1)) begin n_bad++; $display("FAIL tmo_ct_kept got %h want %h", ct_o, P3 ^ 128'h1); end
    busy_len = 1;
    issue(P4, KA, 8'd1, 6);
    n_cmp++; if (err_c1 !== 1'b0) begin n_bad++; $display("FAIL tmo_err_clear got %b want 0", err_c1); end
    n_cmp++; if (ct_o !== P4) begin n_bad++; $display("FAIL tmo_next_ct got %h want %h", ct_o, P4); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL tmo_next_err got %b want 0", err_o); end
  endtask

  task automatic test_back_to_back();
    int n_ld; int n_dn;
    int ld_c [2]; int dn_c [2];
    logic [DATA_W-1:0] ld_d [2];
    n_ld = 0; n_dn = 0;
    for (int i = 0; i < 2; i++) begin ld_c[i] = -1; dn_c[i] = -1; ld_d[i] = '0; end
    busy_len = 1; xor_mask = '0;
    start_i = 1'b1; pt_i = P1; key_i = KA; iter_i = 8'd1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (tgt_load_o) begin
        if (n_ld < 2) begin ld_c[n_ld] = c; ld_d[n_ld] = tgt_data_o; end
        n_ld++;
      end
      if (done_o) begin
        if (n_dn < 2) dn_c[n_dn] = c;
        n_dn++;
      end
      if (c == 1) start_i = 1'b0;
      if (c == 2) begin start_i = 1'b1; pt_i = P5; end
      if (c == 6) start_i = 1'b0;
    end
    n_cmp++; if (n_ld !== 2) begin n_bad++; $display("FAIL b2b_loads got %0d want 2", n_ld); end
    n_cmp++; if (n_dn !== 2) begin n_bad++; $display("FAIL b2b_dones got %0d want 2", n_dn); end
    n_cmp++; if (dn_c[0] !== 4) begin n_bad++; $display("FAIL b2b_done1_at got %0d want 4", dn_c[0]); end
    n_cmp++; if (ld_c[1] !== 6) begin n_bad++; $display("FAIL b2b_load2_at got %0d want 6", ld_c[1]); end
    n_cmp++; if (ld_d[1] !== P5) begin n_bad++; $display("FAIL b2b_load2_data got %h want %h", ld_d[1], P5); end
    n_cmp++; if (dn_c[1] !== 9) begin n_bad++; $display("FAIL b2b_done2_at got %0d want 9", dn_c[1]); end
    n_cmp++; if (ct_o !== P5) begin n_bad++; $display("FAIL b2b_ct got %h want %h", ct_o, P5); end
  endtask

  task automatic test_reset_mid();
    int n_dn;
    n_dn = 0;
    busy_len = 5; xor_mask = '0;
    start_i = 1'b1; pt_i = P2; key_i = KA; iter_i = 8'd1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
    end
    n_cmp++; if (trig_o !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_trig got %b want 1", trig_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", ready_o); end
    n_cmp++; if (trig_o !== 1'b0) begin n_bad++; $display("FAIL midrst_trig got %b want 0", trig_o); end
    n_cmp++; if (tgt_load_o !== 1'b0) begin n_bad++; $display("FAIL midrst_load got %b want 0", tgt_load_o); end
    n_cmp++; if (ct_o !== '0) begin n_bad++; $display("FAIL midrst_ct got %h want 0", ct_o); end
    n_cmp++; if (tgt_data_o !== '0) begin n_bad++; $display("FAIL midrst_tdata got %h want 0", tgt_data_o); end
    for (int c = 0; c < 8; c++) begin
      if (done_o) n_dn++;
      @(negedge clk);
    end
    n_cmp++; if (n_dn !== 0) begin n_bad++; $display("FAIL midrst_done_pulses got %0d want 0", n_dn); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL midrst_stays_idle got %b want 1", ready_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_iter_zero();
    test_multi_iter();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
